// File: rtl/data_output.sv
// data_output: serial audio transmitter. FIFO-buffered 24-bit samples are shifted out MSB-first on bclk/lrclk/serial.
// Build option DATA_OUTPUT_REPEAT_EN: an underrun slot repeats the last popped word instead of sending silence.
module data_output #(
   parameter int DEPTH    = 8,
   parameter int BCLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [23:0] data,
   input  logic        load,
   output logic        full,
   output logic        rpi_interrupt,
   output logic        underrun,
   output logic        bclk,
   output logic        lrclk,
   output logic        serial
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
   localparam logic [PW-1:0] HALF_L   = PW'(DEPTH / 2);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);

   logic [23:0]   mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [DW-1:0] div_cnt_r;
   logic [4:0]    bit_cnt_r;
   logic [23:0]   shift_r;
   logic          bclk_r;
   logic          lrclk_r;
   logic          serial_r;
   logic          rpi_r;
   logic          underrun_r;

   logic [PW-1:0] level_s;
   logic          full_s;
   logic          empty_s;
   logic          tick_s;
   logic          fall_s;
   logic          slot_start_s;
   logic          wr_en_s;
   logic          rd_en_s;
   logic [23:0]   head_s;
   logic [23:0]   under_val_s;
   logic [23:0]   slot_word_s;

   assign level_s      = wr_ptr_r - rd_ptr_r;
   assign full_s       = (level_s == DEPTH_L);
   assign empty_s      = (level_s == {PW{1'b0}});
   assign tick_s       = enable && (div_cnt_r == DIV_LAST);
   assign fall_s       = tick_s && bclk_r;
   assign slot_start_s = fall_s && (bit_cnt_r == 5'd0);
   assign wr_en_s      = load && !full_s;
   assign rd_en_s      = slot_start_s && !empty_s;
   assign head_s       = mem_r[rd_ptr_r[AW-1:0]];
   assign slot_word_s  = empty_s ? under_val_s : head_s;

`ifdef DATA_OUTPUT_REPEAT_EN
   logic [23:0] last_word_r;

   // Remember the most recently popped word for underrun repeat.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_word_r <= 24'h000000;
      end else if (rd_en_s) begin
         last_word_r <= head_s;
      end
   end

   assign under_val_s = last_word_r;
`else
   assign under_val_s = 24'h000000;
`endif

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= data;
      end
   end

   // FIFO pointers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Bit-clock divider, shifter and word select; everything serial idles at 0 while halted.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         div_cnt_r  <= {DW{1'b0}};
         bclk_r     <= 1'b0;
         lrclk_r    <= 1'b0;
         serial_r   <= 1'b0;
         bit_cnt_r  <= 5'd0;
         shift_r    <= 24'h000000;
         underrun_r <= 1'b0;
      end else begin
         div_cnt_r <= (div_cnt_r == DIV_LAST) ? {DW{1'b0}} : div_cnt_r + DIV_ONE;
         if (tick_s) begin
            bclk_r <= ~bclk_r;
         end
         if (slot_start_s) begin
            serial_r  <= slot_word_s[23];
            shift_r   <= {slot_word_s[22:0], 1'b0};
            bit_cnt_r <= 5'd1;
            if (empty_s) begin
               underrun_r <= 1'b1;
            end
         end else if (fall_s) begin
            serial_r <= shift_r[23];
            shift_r  <= {shift_r[22:0], 1'b0};
            // The LSB goes out together with the next channel's word select.
            if (bit_cnt_r == 5'd23) begin
               bit_cnt_r <= 5'd0;
               lrclk_r   <= ~lrclk_r;
            end else begin
               bit_cnt_r <= bit_cnt_r + 5'd1;
            end
         end
      end
   end

   // Refill request from the level at the start of the cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rpi_r <= 1'b0;
      end else begin
         rpi_r <= enable && (level_s <= HALF_L);
      end
   end

   assign full          = full_s;
   assign rpi_interrupt = rpi_r;
   assign underrun      = underrun_r;
   assign bclk          = bclk_r;
   assign lrclk         = lrclk_r;
   assign serial        = serial_r;

endmodule

// File: tb/tb_data_output.sv
// tb_data_output: directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_data_output;

   localparam int DEPTH = 8;
   localparam int DIV   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [23:0] data = 24'h000000;
   logic        load = 1'b0;
   logic        full, rpi_interrupt, underrun, bclk, lrclk, serial;

   data_output #(.DEPTH(DEPTH), .BCLK_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .enable(enable), .data(data), .load(load),
      .full(full), .rpi_interrupt(rpi_interrupt), .underrun(underrun),
      .bclk(bclk), .lrclk(lrclk), .serial(serial)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model state: FIFO as a queue, serial timing from the count of enabled cycles
   logic [23:0] q[$];
   int          en_n = 0;
   logic [23:0] cur = 24'h000000;
   logic [23:0] last = 24'h000000;
   logic        m_bclk = 1'b0, m_lr = 1'b0, m_ser = 1'b0, m_und = 1'b0, m_rpi = 1'b0;
   bit          m_fall = 1'b0;

   // words reassembled from the DUT serial line at model fall events
   logic [23:0] cap = 24'h000000;
   int          cap_n = 0;
   int          falls = 0;
   logic [23:0] words[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_edge();
      int  lvl, k, b;
      bit  push;
      m_fall = 1'b0;
      if (rst) begin
         q.delete();
         en_n = 0; cur = 24'h000000; last = 24'h000000;
         m_bclk = 1'b0; m_lr = 1'b0; m_ser = 1'b0; m_und = 1'b0; m_rpi = 1'b0;
      end else begin
         lvl   = q.size();
         m_rpi = enable && (lvl <= DEPTH / 2);
         push  = load && (lvl < DEPTH);
         if (!enable) begin
            en_n = 0;
            m_bclk = 1'b0; m_lr = 1'b0; m_ser = 1'b0; m_und = 1'b0;
         end else begin
            en_n++;
            m_bclk = ((en_n / DIV) % 2) == 1;
            if (en_n % (2 * DIV) == 0) begin
               m_fall = 1'b1;
               k = en_n / (2 * DIV);
               b = (k - 1) % 24;
               if (b == 0) begin
                  if (lvl > 0) begin
                     cur  = q.pop_front();
                     last = cur;
                  end else begin
`ifdef DATA_OUTPUT_REPEAT_EN
                     cur = last;
`else
                     cur = 24'h000000;
`endif
                     m_und = 1'b1;
                  end
               end
               m_ser = cur[23 - b];
               m_lr  = ((k / 24) % 2) == 1;
            end
         end
         if (push) q.push_back(data);
      end
   endtask

   task automatic compare_and_capture();
      check("bclk", bclk, m_bclk);
      check("lrclk", lrclk, m_lr);
      check("serial", serial, m_ser);
      check("underrun", underrun, m_und);
      check("rpi_interrupt", rpi_interrupt, m_rpi);
      check("full", full, q.size() == DEPTH);
      if (en_n == 0) begin
         cap_n = 0;
      end else if (m_fall) begin
         cap = {cap[22:0], serial};
         cap_n++;
         falls++;
         if (cap_n == 24) begin
            words.push_back(cap);
            cap_n = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_and_capture();
   endtask

   task automatic run_falls(input int n, input int budget);
      int start;
      start = falls;
      for (int i = 0; i < budget && (falls - start) < n; i++) tick();
      check("fall_budget", (falls - start) >= n, 1'b1);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1; enable = 1'b0; load = 1'b0;
      for (int i = 0; i < cycles; i++) tick();
      rst = 1'b0;
   endtask

   task automatic push_word(input logic [23:0] w);
      data = w; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_bclk"}, bclk, 1'b0);
      check({tag, "_lrclk"}, lrclk, 1'b0);
      check({tag, "_serial"}, serial, 1'b0);
      check({tag, "_underrun"}, underrun, 1'b0);
   endtask

   initial begin
      logic [3:0]  bclk_pat;
      logic [23:0] exp_w;
      int          rate;

      // reset then enable
      do_reset(3);
      check_idle("reset");
      check("reset_rpi", rpi_interrupt, 1'b0);
      check("reset_full", full, 1'b0);
      bclk_pat = 4'b0110;
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("first_bclk", bclk, bclk_pat[i]);
      end

      // basic transmit
      do_reset(1);
      push_word(24'hA5A5A5);
      push_word(24'h123456);
      words.delete();
      enable = 1'b1;
      run_falls(48, 48 * 2 * DIV + 20);
      check("basic_words", words.size(), 2);
      if (words.size() >= 2) begin
         check("basic_left", words[0], 24'hA5A5A5);
         check("basic_right", words[1], 24'h123456);
      end

      // full and drop
      do_reset(1);
      for (int i = 1; i <= 9; i++) begin
         push_word(24'(i));
         if (i == 7) check("not_full_7", full, 1'b0);
         if (i == 8) check("full_8", full, 1'b1);
      end
      words.delete();
      enable = 1'b1;
      run_falls(8 * 24, 8 * 24 * 2 * DIV + 20);
      check("drop_words", words.size(), 8);
      for (int i = 0; i < 8 && i < words.size(); i++) check("drop_order", words[i], 32'(i + 1));

      // underrun
      do_reset(1);
      push_word(24'hFFFFFF);
      words.delete();
      enable = 1'b1;
      run_falls(48, 48 * 2 * DIV + 20);
`ifdef DATA_OUTPUT_REPEAT_EN
      exp_w = 24'hFFFFFF;
`else
      exp_w = 24'h000000;
`endif
      check("under_words", words.size(), 2);
      if (words.size() >= 2) begin
         check("under_left", words[0], 24'hFFFFFF);
         check("under_right", words[1], exp_w);
      end
      check("under_flag", underrun, 1'b1);

      // halt mid-word
      do_reset(1);
      push_word(24'h3C3C3C);
      push_word(24'h9ABCDE);
      push_word(24'h555AAA);
      enable = 1'b1;
      run_falls(10, 10 * 2 * DIV + 10);
      enable = 1'b0;
      tick();
      check_idle("halt");
      check("halt_level", q.size(), 2);
      words.delete();
      enable = 1'b1;
      run_falls(24, 24 * 2 * DIV + 20);
      check("halt_words", words.size(), 1);
      if (words.size() >= 1) check("halt_resume", words[0], 24'h9ABCDE);

      // reset mid-frame
      do_reset(1);
      for (int i = 0; i < 7; i++) push_word(24'h100000 + 24'(i));
      enable = 1'b1;
      run_falls(30, 30 * 2 * DIV + 10);
      check("midframe_level", q.size(), 5);
      do_reset(1);
      check_idle("midreset");
      check("midreset_full", full, 1'b0);
      check("midreset_level", q.size(), 0);

      // randomized traffic with varying load rates
      enable = 1'b1;
      rate = 5;
      for (int c = 0; c < 4000; c++) begin
         if (c % 500 == 0) rate = int'($urandom_range(0, 3)) * 10 + 1;
         rst    = ($urandom % 600) == 0;
         if (($urandom % 400) == 0) enable = ~enable;
         load   = ($urandom % 100) < rate;
         data   = 24'($urandom);
         tick();
      end
      rst = 1'b0; load = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
